// File: rtl/logic_latch_pkg.sv
// Shared constants for the latch bank.
//   PRIO_CLR / PRIO_SET      : values for the CLR_PRIORITY parameter
//   MODE_LEVEL / MODE_EDGE   : values for the EDGE_MODE parameter
//   sel_width()              : width of a channel-select field for a given
//                              channel count (never less than one bit)
package logic_latch_pkg;

  localparam int PRIO_CLR   = 1;
  localparam int PRIO_SET   = 0;
  localparam int MODE_LEVEL = 0;
  localparam int MODE_EDGE  = 1;

  function automatic int sel_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/logic_latch_cell.sv
// One set/clear latch channel.
//   clk, rst : clock, synchronous active-high reset
//   d, x, a  : set request, clear request, arm (gates set only)
//   cnt_clr  : clear this channel's event counter this cycle
//   l        : registered latch state
//   cnt      : saturating count of 0->1 transitions of l
//   rise     : combinational, high when l will go 0->1 at the next edge
module logic_latch_cell
  import logic_latch_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int CLR_PRIORITY = 1,
  parameter int EDGE_MODE    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             x,
  input  logic             a,
  input  logic             cnt_clr,
  output logic             l,
  output logic [CNT_W-1:0] cnt,
  output logic             rise
);

  logic             r_l;
  logic             r_dq;
  logic [CNT_W-1:0] r_cnt;
  logic             w_set;
  logic             w_l_next;

  always_comb begin
    w_set = a & ((EDGE_MODE == MODE_EDGE) ? (d & ~r_dq) : d);
    w_l_next = r_l;
    unique case ({w_set, x})
      2'b10:   w_l_next = 1'b1;
      2'b01:   w_l_next = 1'b0;
      2'b11:   w_l_next = (CLR_PRIORITY == PRIO_CLR) ? 1'b0 : 1'b1;
      default: w_l_next = r_l;
    endcase
  end

  assign rise = ~r_l & w_l_next;

  always_ff @(posedge clk) begin
    // d_q tracks d even in reset so a level held through reset is not an edge
    r_dq <= d;
    if (rst) begin
      r_l   <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_l <= w_l_next;
      // a rise coinciding with a clear is counted after the clear
      if (cnt_clr)
        r_cnt <= rise ? CNT_W'(1) : '0;
      else if (rise && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign l   = r_l;
  assign cnt = r_cnt;

endmodule

// File: rtl/logic_latch_bank.sv
// Bank of CH registered set/clear latch channels.
//   clk, rst   : clock, synchronous active-high reset
//   d, x, a    : per-channel set, clear, arm
//   cnt_sel    : counter readback / clear channel select
//   cnt_clr    : clear counter of channel cnt_sel (ignored if cnt_sel >= CH)
//   l          : latched state per channel
//   l_any      : OR of l
//   evt        : one-cycle pulse in the first cycle any channel shows 1
//   cnt_out    : counter of channel cnt_sel, 0 if cnt_sel >= CH
module logic_latch_bank
  import logic_latch_pkg::*;
#(
  parameter int CH           = 8,
  parameter int CNT_W        = 4,
  parameter int CLR_PRIORITY = 1,
  parameter int EDGE_MODE    = 0,
  localparam int SEL_W       = sel_width(CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    d,
  input  logic [CH-1:0]    x,
  input  logic [CH-1:0]    a,
  input  logic [SEL_W-1:0] cnt_sel,
  input  logic             cnt_clr,
  output logic [CH-1:0]    l,
  output logic             l_any,
  output logic             evt,
  output logic [CNT_W-1:0] cnt_out
);

  logic [CH-1:0]    w_rise;
  logic [CH-1:0]    w_clr;
  logic [CNT_W-1:0] w_cnt [CH];
  logic             r_evt;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    assign w_clr[gi] = cnt_clr & (cnt_sel == SEL_W'(gi));

    logic_latch_cell #(
      .CNT_W       (CNT_W),
      .CLR_PRIORITY(CLR_PRIORITY),
      .EDGE_MODE   (EDGE_MODE)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .d      (d[gi]),
      .x      (x[gi]),
      .a      (a[gi]),
      .cnt_clr(w_clr[gi]),
      .l      (l[gi]),
      .cnt    (w_cnt[gi]),
      .rise   (w_rise[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_evt <= 1'b0;
    else     r_evt <= |w_rise;
  end

  // out-of-range select matches no channel and reads back zero
  always_comb begin
    cnt_out = '0;
    for (int unsigned i = 0; i < CH; i++)
      if (cnt_sel == SEL_W'(i)) cnt_out = w_cnt[i];
  end

  assign l_any = |l;
  assign evt   = r_evt;

endmodule

// File: tb/tb_logic_latch_bank.sv
module tb_logic_latch_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] d = '0, x = '0, a = '0;
  logic [1:0] cnt_sel = '0;
  logic       cnt_clr = 1'b0;

  // instance 0: clear priority, level; 1: set priority, level;
  // 2: clear priority, edge; 3: three channels (out-of-range select)
  logic [3:0] o_l   [4];
  logic       o_any [4];
  logic       o_evt [4];
  logic [1:0] o_cnt [4];
  logic [2:0] l_n;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic_latch_bank #(.CH(4), .CNT_W(2), .CLR_PRIORITY(1), .EDGE_MODE(0)) dut_c (
    .clk(clk), .rst(rst), .d(d), .x(x), .a(a), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr),
    .l(o_l[0]), .l_any(o_any[0]), .evt(o_evt[0]), .cnt_out(o_cnt[0]));

  logic_latch_bank #(.CH(4), .CNT_W(2), .CLR_PRIORITY(0), .EDGE_MODE(0)) dut_s (
    .clk(clk), .rst(rst), .d(d), .x(x), .a(a), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr),
    .l(o_l[1]), .l_any(o_any[1]), .evt(o_evt[1]), .cnt_out(o_cnt[1]));

  logic_latch_bank #(.CH(4), .CNT_W(2), .CLR_PRIORITY(1), .EDGE_MODE(1)) dut_e (
    .clk(clk), .rst(rst), .d(d), .x(x), .a(a), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr),
    .l(o_l[2]), .l_any(o_any[2]), .evt(o_evt[2]), .cnt_out(o_cnt[2]));

  logic_latch_bank #(.CH(3), .CNT_W(2), .CLR_PRIORITY(1), .EDGE_MODE(0)) dut_n (
    .clk(clk), .rst(rst), .d(d[2:0]), .x(x[2:0]), .a(a[2:0]), .cnt_sel(cnt_sel),
    .cnt_clr(cnt_clr), .l(l_n), .l_any(o_any[3]), .evt(o_evt[3]), .cnt_out(o_cnt[3]));

  assign o_l[3] = {1'b0, l_n};

  // reference model: plain integers per instance/channel
  int nch      [4] = '{4, 4, 4, 3};
  int prio_clr [4] = '{1, 0, 1, 1};
  int edge_m   [4] = '{0, 0, 1, 0};
  int m_l   [4][4];
  int m_dq  [4][4];
  int m_cnt [4][4];
  int m_evt [4];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] vd, input logic [3:0] vx, input logic [3:0] va,
                      input logic [1:0] vs, input logic vc, input logic vr);
    int s, nl, rise, any_rise, exp_l;
    @(negedge clk);
    d = vd; x = vx; a = va; cnt_sel = vs; cnt_clr = vc; rst = vr;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      any_rise = 0;
      for (int i = 0; i < nch[k]; i++) begin
        if (vr) begin
          m_l[k][i] = 0;
          m_cnt[k][i] = 0;
        end else begin
          s = (va[i] && (edge_m[k] != 0 ? (vd[i] && m_dq[k][i] == 0) : vd[i])) ? 1 : 0;
          nl = m_l[k][i];
          if (s != 0 && vx[i]) nl = prio_clr[k] != 0 ? 0 : 1;
          else if (s != 0)     nl = 1;
          else if (vx[i])      nl = 0;
          rise = (m_l[k][i] == 0 && nl == 1) ? 1 : 0;
          if (rise != 0) any_rise = 1;
          if (vc && int'(vs) == i) m_cnt[k][i] = rise;
          else if (rise != 0 && m_cnt[k][i] < 3) m_cnt[k][i] = m_cnt[k][i] + 1;
          m_l[k][i] = nl;
        end
        m_dq[k][i] = vd[i] ? 1 : 0;
      end
      m_evt[k] = vr ? 0 : any_rise;
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_l = 0;
      for (int i = 0; i < nch[k]; i++) exp_l += m_l[k][i] << i;
      check($sformatf("l[%0d]", k), int'(o_l[k]), exp_l);
      check($sformatf("l_any[%0d]", k), int'(o_any[k]), exp_l != 0 ? 1 : 0);
      check($sformatf("evt[%0d]", k), int'(o_evt[k]), m_evt[k]);
      check($sformatf("cnt_out[%0d]", k), int'(o_cnt[k]),
            int'(cnt_sel) < nch[k] ? m_cnt[k][cnt_sel] : 0);
    end
  endtask

  initial begin
    // reset with d high, then release with d still high
    step(4'hF, 4'h0, 4'hF, 2'd0, 1'b0, 1'b1);
    step(4'hF, 4'h0, 4'hF, 2'd1, 1'b0, 1'b1);
    step(4'hF, 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
    step(4'hF, 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
    step(4'h0, 4'hF, 4'hF, 2'd0, 1'b0, 1'b0);
    // level set / clear
    step(4'h1, 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
    step(4'h0, 4'h1, 4'hF, 2'd0, 1'b0, 1'b0);
    // set/clear coincidence
    step(4'h2, 4'h2, 4'hF, 2'd1, 1'b0, 1'b0);
    step(4'h0, 4'h0, 4'hF, 2'd1, 1'b0, 1'b0);
    step(4'h0, 4'hF, 4'hF, 2'd1, 1'b0, 1'b0);
    // arm mask, then armed, then disarm while set
    step(4'hF, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    step(4'hF, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
    step(4'hF, 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
    step(4'hF, 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    step(4'h0, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0);
    // counter saturation on channel 2, then clear with a coincident rise
    for (int n = 0; n < 5; n++) begin
      step(4'h4, 4'h0, 4'hF, 2'd2, 1'b0, 1'b0);
      step(4'h0, 4'h4, 4'hF, 2'd2, 1'b0, 1'b0);
    end
    step(4'h4, 4'h0, 4'hF, 2'd2, 1'b1, 1'b0);
    step(4'h0, 4'h4, 4'hF, 2'd2, 1'b1, 1'b0);
    // d[0] held high across clears, then low, then high again
    step(4'h1, 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
    step(4'h1, 4'h1, 4'hF, 2'd0, 1'b0, 1'b0);
    step(4'h1, 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
    step(4'h1, 4'h1, 4'hF, 2'd0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
    step(4'h1, 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
    // out-of-range select on the three-channel instance
    step(4'h7, 4'h0, 4'hF, 2'd3, 1'b1, 1'b0);
    step(4'h0, 4'h0, 4'hF, 2'd0, 1'b0, 1'b0);
    // reset in the middle of activity
    step(4'hF, 4'h0, 4'hF, 2'd0, 1'b1, 1'b1);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(4'($urandom), 4'($urandom) & 4'($urandom), 4'($urandom) | 4'($urandom),
           2'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
